// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline sequencer: FSM state enum, display codes, bus width defaults.
// Combinational helpers only; no clocked logic lives here.
package pipeline_sequencer_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 10;
  localparam int DIFF_W     = 10;
  localparam int NOTE_W     = 3;
  localparam int CODE_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_GET_AUDIO = 3'd2,
    ST_DO_FFT    = 3'd3,
    ST_FIND_FREQ = 3'd4,
    ST_END       = 3'd5
  } state_t;

  localparam logic [CODE_W-1:0] CODE_IDLE      = 3'd0;
  localparam logic [CODE_W-1:0] CODE_GET_AUDIO = 3'd1;
  localparam logic [CODE_W-1:0] CODE_DO_FFT    = 3'd2;
  localparam logic [CODE_W-1:0] CODE_FIND_FREQ = 3'd3;
  localparam logic [CODE_W-1:0] CODE_END       = 3'd4;

  // IDLE and START share a display code; the panel only distinguishes working stages.
  function automatic logic [CODE_W-1:0] state_code(input state_t s);
    case (s)
      ST_GET_AUDIO: return CODE_GET_AUDIO;
      ST_DO_FFT:    return CODE_DO_FFT;
      ST_FIND_FREQ: return CODE_FIND_FREQ;
      ST_END:       return CODE_END;
      default:      return CODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_sequencer_stage_handshake.sv
// Per-stage go/done handshake; go rises one cycle after stage entry, drops on the edge sampling done.
// Latency: advance/timeout are combinational on done; go is registered. Watchdog under SEQ_WATCHDOG_EN.
module pipeline_sequencer_stage_handshake #(
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic done,
  output logic go,
  output logic advance,
  output logic timeout
);

  assign advance = active & done;

`ifdef SEQ_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  // Held at zero outside the stage so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign timeout = active & ~done & (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go <= 1'b0;
    end else begin
      go <= active & ~done & ~timeout;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Sequences capture -> transform -> search stages over a shared sample memory; optional SEQ_WATCHDOG_EN.
// Latency: stage advance one edge after done; mux combinational from state. Stages wait on done (or watchdog).
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     continuous,
  output logic                     busy,
  output logic [CODE_W-1:0]        current_state,
  output logic                     cycle_done,
  output logic                     timeout_err,
  output logic                     audio_go,
  input  logic                     audio_done,
  input  logic [ADDR_W-1:0]        audio_addr,
  input  logic                     audio_we,
  input  logic [DATA_W-1:0]        audio_wdata,
  output logic                     fft_go,
  input  logic                     fft_done,
  input  logic [ADDR_W-1:0]        fft_addr,
  input  logic                     fft_we,
  input  logic [DATA_W-1:0]        fft_wdata,
  output logic                     freq_go,
  input  logic                     freq_done,
  input  logic [ADDR_W-1:0]        freq_addr,
  input  logic signed [DIFF_W-1:0] freq_diff,
  input  logic [NOTE_W-1:0]        freq_note,
  output logic                     mem_rst_n,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic signed [DIFF_W-1:0] res_diff,
  output logic [NOTE_W-1:0]        res_note,
  output logic                     res_valid
);

  state_t     state_q, state_d;
  logic [1:0] rst_sync;
  logic       run;
  logic       act_a, act_f, act_q;
  logic       adv_a, adv_f, adv_q;
  logic       tmo_a, tmo_f, tmo_q;

  // Reset asserts immediately everywhere; the FSM only starts moving once release has crossed two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  assign act_a = (state_q == ST_GET_AUDIO);
  assign act_f = (state_q == ST_DO_FFT);
  assign act_q = (state_q == ST_FIND_FREQ);

  pipeline_sequencer_stage_handshake #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_hs_audio (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (act_a),
    .done    (audio_done),
    .go      (audio_go),
    .advance (adv_a),
    .timeout (tmo_a)
  );

  pipeline_sequencer_stage_handshake #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_hs_fft (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (act_f),
    .done    (fft_done),
    .go      (fft_go),
    .advance (adv_f),
    .timeout (tmo_f)
  );

  pipeline_sequencer_stage_handshake #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_hs_freq (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (act_q),
    .done    (freq_done),
    .go      (freq_go),
    .advance (adv_q),
    .timeout (tmo_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (run) begin
      state_q <= state_d;
    end
  end

  // done is checked ahead of timeout so a stage finishing on its last allowed cycle still advances.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_START;
      ST_START:     state_d = ST_GET_AUDIO;
      ST_GET_AUDIO: begin
        if (adv_a)      state_d = ST_DO_FFT;
        else if (tmo_a) state_d = ST_END;
      end
      ST_DO_FFT: begin
        if (adv_f)      state_d = ST_FIND_FREQ;
        else if (tmo_f) state_d = ST_END;
      end
      ST_FIND_FREQ: begin
        if (adv_q || tmo_q) state_d = ST_END;
      end
      ST_END:       state_d = continuous ? ST_START : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rst_n <= 1'b0;
    end else if (run) begin
      mem_rst_n <= !(state_d == ST_IDLE || state_d == ST_END);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (run) begin
      if (state_q == ST_IDLE && start) begin
        timeout_err <= 1'b0;
      end else if (tmo_a || tmo_f || tmo_q) begin
        timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_diff  <= '0;
      res_note  <= '0;
      res_valid <= 1'b0;
    end else if (run && adv_q) begin
      res_diff  <= freq_diff;
      res_note  <= freq_note;
      res_valid <= 1'b1;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign cycle_done    = (state_q == ST_END);
  assign current_state = state_code(state_q);

  // Search stage only reads, so its write strobe and data are forced low.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_GET_AUDIO: begin
        mem_addr  = audio_addr;
        mem_we    = audio_we;
        mem_wdata = audio_wdata;
      end
      ST_DO_FFT: begin
        mem_addr  = fft_addr;
        mem_we    = fft_we;
        mem_wdata = fft_wdata;
      end
      ST_FIND_FREQ: mem_addr = freq_addr;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: stage-level reference model checked every cycle, plus directed literal checks.
module tb_pipeline_sequencer;

  localparam int AW = 11;
  localparam int DW = 10;
`ifdef SEQ_WATCHDOG_EN
  localparam int TO = 64;
  localparam bit WD = 1'b1;
  localparam int DA = 40, DF = 30, DQ = 20;
  localparam int A_BUSY = 95;
`else
  localparam int TO = 1048576;
  localparam bit WD = 1'b0;
  localparam int DA = 2048, DF = 500, DQ = 300;
  localparam int A_BUSY = 2853;
`endif

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, continuous = 1'b0;
  logic busy, cycle_done, timeout_err;
  logic [2:0] current_state;
  logic audio_go, fft_go, freq_go;
  logic audio_done = 1'b0, fft_done = 1'b0, freq_done = 1'b0;
  logic [AW-1:0] audio_addr = '0, fft_addr = '0, freq_addr = '0;
  logic audio_we = 1'b0, fft_we = 1'b0;
  logic [DW-1:0] audio_wdata = '0, fft_wdata = '0;
  logic signed [9:0] freq_diff = '0;
  logic [2:0] freq_note = '0;
  logic mem_rst_n, mem_we, res_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic signed [9:0] res_diff;
  logic [2:0] res_note;

  pipeline_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .busy(busy), .current_state(current_state), .cycle_done(cycle_done), .timeout_err(timeout_err),
    .audio_go(audio_go), .audio_done(audio_done), .audio_addr(audio_addr), .audio_we(audio_we),
    .audio_wdata(audio_wdata),
    .fft_go(fft_go), .fft_done(fft_done), .fft_addr(fft_addr), .fft_we(fft_we), .fft_wdata(fft_wdata),
    .freq_go(freq_go), .freq_done(freq_done), .freq_addr(freq_addr), .freq_diff(freq_diff),
    .freq_note(freq_note),
    .mem_rst_n(mem_rst_n), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .res_diff(res_diff), .res_note(res_note), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Model: stage index (0 idle,1 start,2 audio,3 fft,4 freq,5 end) and cycles spent in it.
  int m_st = 0, m_age = 0;
  logic signed [9:0] m_diff = '0;
  logic [2:0] m_note = '0;
  bit m_valid = 1'b0, m_terr = 1'b0, m_run = 1'b1, chk_en = 1'b0;

  function automatic bit stage_done(input int s);
    case (s)
      2: return audio_done;
      3: return fft_done;
      4: return freq_done;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_age <= 0; m_diff <= '0; m_note <= '0; m_valid <= 1'b0; m_terr <= 1'b0;
    end else if (m_run) begin
      case (m_st)
        0: if (start) begin m_st <= 1; m_age <= 0; m_terr <= 1'b0; end
        1: begin m_st <= 2; m_age <= 0; end
        2, 3, 4: begin
          if (stage_done(m_st)) begin
            m_st <= m_st + 1; m_age <= 0;
            if (m_st == 4) begin m_diff <= freq_diff; m_note <= freq_note; m_valid <= 1'b1; end
          end else if (WD && m_age == TO - 1) begin
            m_st <= 5; m_age <= 0; m_terr <= 1'b1;
          end else begin
            m_age <= m_age + 1;
          end
        end
        default: begin m_st <= continuous ? 1 : 0; m_age <= 0; end
      endcase
    end
  end

  function automatic int exp_cs();
    case (m_st)
      2: return 1;
      3: return 2;
      4: return 3;
      5: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic longint exp_addr();
    case (m_st)
      2: return longint'(audio_addr);
      3: return longint'(fft_addr);
      4: return longint'(freq_addr);
      default: return 0;
    endcase
  endfunction

  function automatic longint exp_we();
    case (m_st)
      2: return longint'(audio_we);
      3: return longint'(fft_we);
      default: return 0;
    endcase
  endfunction

  function automatic longint exp_wdata();
    case (m_st)
      2: return longint'(audio_wdata);
      3: return longint'(fft_wdata);
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_st != 0);
      chk("current_state", current_state, exp_cs());
      chk("cycle_done", cycle_done, m_st == 5);
      chk("mem_rst_n", mem_rst_n, !(m_st == 0 || m_st == 5));
      chk("audio_go", audio_go, m_st == 2 && m_age >= 1);
      chk("fft_go", fft_go, m_st == 3 && m_age >= 1);
      chk("freq_go", freq_go, m_st == 4 && m_age >= 1);
      chk("mem_addr", mem_addr, exp_addr());
      chk("mem_we", mem_we, exp_we());
      chk("mem_wdata", mem_wdata, exp_wdata());
      chk("res_diff", longint'(res_diff), longint'(m_diff));
      chk("res_note", res_note, m_note);
      chk("res_valid", res_valid, m_valid);
      chk("timeout_err", timeout_err, m_terr);
    end
  end

  // Stimulus: done of the active stage rises once it has spent dly[k] cycles there (-1 = never).
  int dly[3] = '{0, 0, 0};
  bit rnd = 1'b0, rdat = 1'b1;
  int hold = 0;
  int seq[$];

  function automatic logic done_for(input int k);
    if (m_st == k + 2) return (dly[k] >= 0) && (m_age >= dly[k]);
    return rnd ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic drive();
    for (int k = 0; k < 3; k++)
      if (rnd && m_st == k + 2 && m_age == 0) dly[k] = $urandom_range(0, WD ? 90 : 40);
    audio_done = done_for(0);
    fft_done   = done_for(1);
    freq_done  = done_for(2);
    if (rdat) begin
      audio_addr = AW'($urandom); fft_addr = AW'($urandom); freq_addr = AW'($urandom);
      audio_we = logic'($urandom_range(0, 1)); fft_we = logic'($urandom_range(0, 1));
      audio_wdata = DW'($urandom); fft_wdata = DW'($urandom);
      freq_diff = 10'($urandom); freq_note = 3'($urandom);
    end
    if (rnd) begin
      start = ($urandom_range(0, 99) < 6);
      continuous = ($urandom_range(0, 3) != 0);
    end
    if (hold > 0) begin start = 1'b0; hold--; end
  endtask

  task automatic tick();
    @(posedge clk); #1; drive();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_idle(input int drop_after, input int limit, output int bc, output int pl, output int ml);
    int last;
    bc = 0; pl = 0; ml = 0; seq.delete(); last = current_state;
    for (int i = 0; i < limit && busy; i++) begin
      bc++;
      if (cycle_done) pl++;
      if (!mem_rst_n) ml++;
      if (drop_after > 0 && pl >= drop_after && !cycle_done) continuous = 1'b0;
      tick();
      if (current_state != last) begin seq.push_back(current_state); last = current_state; end
    end
  endtask

  task automatic wait_cs(input int code, input int limit, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      tick();
      hit = (current_state == code);
    end
    chk(nm, hit, 1);
  endtask

  task automatic reset_pulse();
    #3 rst_n = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b1; start = 1'b0; hold = 3;
  endtask

  int bc, pl, ml, n;
  int exp_a[5] = '{1, 2, 3, 4, 0};

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0); chk("rst_state", current_state, 0); chk("rst_mem_rst_n", mem_rst_n, 0);
    chk("rst_res_valid", res_valid, 0); chk("rst_timeout_err", timeout_err, 0);
    chk("rst_go", {audio_go, fft_go, freq_go}, 0);
    chk_en = 1'b1;
    tick(); tick();
    #3 rst_n = 1'b1;
    tick(); tick(); tick();

    // Single cycle with long stage delays.
    dly = '{DA, DF, DQ}; continuous = 1'b0;
    pulse_start();
    run_idle(0, 6000, bc, pl, ml);
    chk("A_busy_cycles", bc, A_BUSY);
    chk("A_cycle_done_pulses", pl, 1);
    chk("A_seq_len", seq.size(), 5);
    for (int k = 0; k < 5 && k < seq.size(); k++) chk("A_seq_state", seq[k], exp_a[k]);
    chk("A_idle_mem_rst_n", mem_rst_n, 0);

    // Three back-to-back cycles in continuous mode.
    tick(); dly = '{3, 4, 5}; continuous = 1'b1;
    pulse_start();
    run_idle(2, 200, bc, pl, ml);
    chk("B_busy_cycles", bc, 51);
    chk("B_cycle_done_pulses", pl, 3);
    chk("B_mem_rst_low", ml, 3);
    chk("B_seq_len", seq.size(), 15);

    // Result latch and hold.
    tick(); rdat = 1'b0; dly = '{2, 2, 3}; continuous = 1'b1;
    freq_diff = -10'sd37; freq_note = 3'd5;
    pulse_start();
    wait_cs(4, 40, "C_reach_end");
    chk("C_res_diff", longint'(res_diff), -37); chk("C_res_note", res_note, 5); chk("C_res_valid", res_valid, 1);
    freq_diff = 10'sd100; freq_note = 3'd1;
    wait_cs(1, 10, "C_reach_audio");
    chk("C_hold_diff", longint'(res_diff), -37); chk("C_hold_note", res_note, 5);
    continuous = 1'b0;
    run_idle(0, 100, bc, pl, ml);

    // Stalled transform stage: watchdog or indefinite wait; memory mux follows selected stage only.
    tick(); dly = '{1, -1, 1};
    audio_we = 1'b0; fft_we = 1'b0;
    pulse_start();
    wait_cs(2, 20, "D_reach_fft");
    n = 0;
    for (int i = 0; i < 200 && current_state == 2; i++) begin
      n++;
      if (n == 5) begin
        audio_we = 1'b1; fft_we = 1'b0; #1 chk("D_audio_we_ignored", mem_we, 0);
        audio_we = 1'b0; fft_we = 1'b1; #1 chk("D_fft_we_passed", mem_we, 1);
        fft_we = 1'b0; start = 1'b1;
      end
      tick(); start = 1'b0;
    end
`ifdef SEQ_WATCHDOG_EN
    chk("D_fft_cycles", n, 64);
    chk("D_end_after_timeout", current_state, 4);
    chk("D_timeout_err", timeout_err, 1);
    run_idle(0, 20, bc, pl, ml);
    dly = '{1, 1, 1};
    pulse_start();
    chk("D_err_cleared", timeout_err, 0);
`else
    chk("D_fft_cycles", n, 200);
    chk("D_still_fft", current_state, 2);
    chk("D_no_timeout_err", timeout_err, 0);
    dly[1] = 0;
`endif
    run_idle(0, 100, bc, pl, ml);

    // Reset mid-transform with write strobe high, then synchronised release.
    tick(); dly = '{0, -1, 0}; fft_we = 1'b1; fft_addr = 11'd5;
    pulse_start();
    wait_cs(2, 10, "E_reach_fft");
    tick(); tick();
    chk("E_pre_go", fft_go, 1); chk("E_pre_we", mem_we, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("E_we", mem_we, 0); chk("E_go", fft_go, 0); chk("E_state", current_state, 0);
    chk("E_busy", busy, 0); chk("E_res_valid", res_valid, 0); chk("E_mem_rst_n", mem_rst_n, 0);
    tick(); tick();
    #3 rst_n = 1'b1; start = 1'b1; m_run = 1'b0;
    @(posedge clk); #1;
    chk("E_sync_first_edge", busy, 0);
    start = 1'b0; m_run = 1'b1; fft_we = 1'b0;
    tick(); tick();

    // Randomised traffic with occasional resets.
    rnd = 1'b1; rdat = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (i % 1700 == 850) reset_pulse();
      else tick();
    end
    rnd = 1'b0; start = 1'b0; continuous = 1'b0; dly = '{0, 0, 0};
    run_idle(0, 300, bc, pl, ml);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
